// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one L2 port between the L1 icache and dcache miss ports.
// The winning request is latched so the L2 side never sees L1 inputs combinationally.
module cache_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              icache_pmem_read,
  input  logic [ADDR_W-1:0] icache_pmem_addr,
  output logic              icache_pmem_resp,
  input  logic              dcache_pmem_read,
  input  logic              dcache_pmem_write,
  input  logic [ADDR_W-1:0] dcache_pmem_addr,
  input  logic [LINE_W-1:0] dcache_pmem_wdata,
  output logic              dcache_pmem_resp,
  output logic [LINE_W-1:0] pmem_rdata_l1,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp,
  output logic [15:0]       contention_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]   lat_addr_q, lat_addr_d;
  logic [LINE_W-1:0]   lat_wdata_q, lat_wdata_d;
  logic                lat_write_q, lat_write_d;
  logic [15:0]         contention_count_q, contention_count_d;

  logic i_req, d_req, grant_i, grant_d;

  assign i_req = icache_pmem_read;
  assign d_req = dcache_pmem_read | dcache_pmem_write;

  // State register and grant latches
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q            <= IDLE;
      last_grant_q       <= 1'b0;
      lat_addr_q         <= '0;
      lat_wdata_q        <= '0;
      lat_write_q        <= 1'b0;
      contention_count_q <= 16'd0;
    end else begin
      state_q            <= state_d;
      last_grant_q       <= last_grant_d;
      lat_addr_q         <= lat_addr_d;
      lat_wdata_q        <= lat_wdata_d;
      lat_write_q        <= lat_write_d;
      contention_count_q <= contention_count_d;
    end
  end

  // Next-state, arbitration and grant latching
  always_comb begin
    state_d            = state_q;
    last_grant_d       = last_grant_q;
    lat_addr_d         = lat_addr_q;
    lat_wdata_d        = lat_wdata_q;
    lat_write_d        = lat_write_q;
    contention_count_d = contention_count_q;
    grant_i            = 1'b0;
    grant_d            = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req && d_req) begin
          // Contention: the requester not served last time wins
          grant_i = last_grant_q;
          grant_d = ~last_grant_q;
          if (contention_count_q != 16'hFFFF) begin
            contention_count_d = contention_count_q + 16'd1;
          end else begin
            contention_count_d = contention_count_q;
          end
        end else begin
          grant_i = i_req;
          grant_d = d_req;
        end
        if (grant_i) begin
          state_d      = SERVE_I;
          lat_addr_d   = icache_pmem_addr;
          last_grant_d = 1'b0;
        end else if (grant_d) begin
          state_d      = SERVE_D;
          lat_addr_d   = dcache_pmem_addr;
          lat_wdata_d  = dcache_pmem_wdata;
          lat_write_d  = dcache_pmem_write;
          last_grant_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SERVE_I: begin
        if (l2_resp) begin
          state_d = DONE;
        end else begin
          state_d = SERVE_I;
        end
      end
      SERVE_D: begin
        if (l2_resp) begin
          state_d = DONE;
        end else begin
          state_d = SERVE_D;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign l2_read          = (state_q == SERVE_I) | ((state_q == SERVE_D) & ~lat_write_q);
  assign l2_write         = (state_q == SERVE_D) & lat_write_q;
  assign l2_addr          = lat_addr_q;
  assign l2_wdata         = lat_wdata_q;
  assign icache_pmem_resp = l2_resp & (state_q == SERVE_I);
  assign dcache_pmem_resp = l2_resp & (state_q == SERVE_D);
  assign pmem_rdata_l1    = l2_rdata;
  assign contention_count = contention_count_q;

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Sequential arbiter sharing the single L2 / physical-memory port between the L1 icache and L1 dcache miss ports. Both L1 caches issue 128-bit line reads, and the dcache also issues write-backs. The arbiter serializes these onto the shared port with round-robin priority on contention. It latches the winning request, steers `l2_resp` back only to the granted requester, and keeps a saturating contention counter for performance analysis.

## Interface
- `ADDR_W`, default 16: line address width (`lc3b_word`).
- `LINE_W`, default 128: line width (`lc3b_datbus`).
- `clk` input 1: system clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high; forces IDLE and clears all registers.
- `icache_pmem_read` input 1: icache line-fill request, held until `icache_pmem_resp`.
- `icache_pmem_addr` input ADDR_W: icache line address.
- `icache_pmem_resp` output 1: icache transaction complete.
- `dcache_pmem_read` input 1: dcache line-fill request.
- `dcache_pmem_write` input 1: dcache write-back request.
- `dcache_pmem_addr` input ADDR_W: dcache line address.
- `dcache_pmem_wdata` input LINE_W: dcache write-back line.
- `dcache_pmem_resp` output 1: dcache transaction complete.
- `pmem_rdata_l1` output LINE_W: `l2_rdata` broadcast to both L1s; valid only with a resp.
- `l2_read` output 1: read strobe to L2.
- `l2_write` output 1: write strobe to L2.
- `l2_addr` output ADDR_W: latched granted address.
- `l2_wdata` output LINE_W: latched dcache write data.
- `l2_rdata` input LINE_W: L2 read data, valid with `l2_resp`.
- `l2_resp` input 1: L2 transaction complete (one-cycle pulse).
- `contention_count` output 16: number of IDLE cycles with both requesters pending, saturating.

## Operation
- State register `{IDLE, SERVE_I, SERVE_D, DONE}`.
- Additional registers: `last_grant` (0 = I, 1 = D), `lat_addr`, `lat_wdata`, `lat_write`, `contention_count`.
- Request terms:
  - `i_req = icache_pmem_read`.
  - `d_req = dcache_pmem_read | dcache_pmem_write`.
- IDLE behaviour:
  - Only `i_req` pending: go to SERVE_I.
  - Only `d_req` pending: go to SERVE_D.
  - Both pending: grant the requester opposite `last_grant`, and increment `contention_count`, which saturates at 0xFFFF.
  - Neither pending: stay in IDLE.
- Grant actions on the IDLE→SERVE_x transition:
  - Latch the requester's address into `lat_addr`.
  - For D, latch `dcache_pmem_wdata` into `lat_wdata`, and set `lat_write = dcache_pmem_write`.
  - Set `last_grant` to the winner.
- If `dcache_pmem_read` and `dcache_pmem_write` are both high, this is a protocol violation. Write wins (`lat_write = 1`).
- Strobes to L2:
  - `l2_read = (SERVE_I) | (SERVE_D & ~lat_write)`.
  - `l2_write = SERVE_D & lat_write`.
  - `l2_addr = lat_addr`.
  - `l2_wdata = lat_wdata`.
- No combinational path exists from L1 request inputs to `l2_*` outputs.
- Responses back to L1:
  - `icache_pmem_resp = l2_resp & SERVE_I`.
  - `dcache_pmem_resp = l2_resp & SERVE_D`.
  - `pmem_rdata_l1 = l2_rdata`, passed through combinationally.
- On `l2_resp` in SERVE_x: go to DONE. DONE always goes to IDLE next cycle. This gives the requester one cycle to drop its request before re-arbitration.
- `l2_resp` in IDLE or DONE is ignored and forwarded to neither L1.
- Reset values:
  - State IDLE, `last_grant = 0`, so the first contention is granted to D.
  - `lat_*` = 0, `contention_count = 0`.
  - All outputs 0.

## Timing
- Request first seen in IDLE at cycle t: SERVE_x and the L2 strobe both at t+1. Grant latency is 1 cycle.
- `l2_resp` at cycle k: L1 resp at cycle k (combinational); DONE at k+1 with strobes low; IDLE at k+2.
- Earliest next strobe after a response is k+3.
- Strobes stay continuously high from grant through the `l2_resp` cycle.
- `l2_addr` and `l2_wdata` stay stable for the whole grant, even if the L1 inputs change.
- A request arriving while a grant is in progress waits. It is evaluated in the next IDLE cycle.
- Back-to-back contention alternates grants: D, I, D, …
- An asynchronous `reset` mid-transaction has immediate effect:
  - State goes to IDLE and all strobes and resps go low.
  - A stale `l2_resp` after reset is ignored.

## Test plan
- Icache-only read:
  - Stimulus: `icache_pmem_read = 1`, addr 0x1230 at cycle 0; `l2_resp` with `l2_rdata` = 0xA5…A5 at cycle 5.
  - Required: `l2_read = 1` and `l2_addr = 0x1230` for cycles 1–5; `icache_pmem_resp = 1` with rdata = 0xA5…A5 at cycle 5; `l2_read = 0` at cycle 6; `dcache_pmem_resp` never asserts.
- Dcache write-back:
  - Stimulus: `dcache_pmem_write = 1`, addr 0x4000, wdata 0x0123…CDEF; the L1 changes addr to 0xFFFF at cycle 2.
  - Required: `l2_write = 1`; `l2_addr` stays 0x4000 and `l2_wdata` stays unchanged until `l2_resp`; `l2_read` stays 0.
- Simultaneous requests from reset, with both held high:
  - Required grant order: D first, then I, then D.
  - Required: `contention_count` increments once per contended IDLE cycle (1, 2, 3).
- Read+write violation:
  - Stimulus: `dcache_pmem_read = dcache_pmem_write = 1`.
  - Required: only `l2_write` asserts.
- Reset mid-grant:
  - Stimulus: assert `reset` in SERVE_I; then pulse `l2_resp` after reset is released.
  - Required: all outputs 0 immediately on reset; no L1 resp for the stale `l2_resp`; `contention_count = 0`.
- Saturation:
  - Stimulus: preload or force 65 536+ contended cycles.
  - Required: `contention_count` holds at 0xFFFF and does not wrap.
